gc_iteration_sequencer: RTL

- Global Controller iteration-space sequencer for the processor array.
- Steps a DIMENSION-deep loop nest in lexicographic order, innermost dimension first.
- Drives per-dimension indices and last flags to the array-wide control path.
- Detects iteration-space completion by feeding the last flags into a reduction_and instance.

---
 rtl/gc_iteration_sequencer_pkg.sv | 12 +
 rtl/reduction_and.sv | 11 +
 rtl/gc_iteration_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gc_iteration_sequencer_pkg.sv
// Shared Global Controller definitions: iteration-sequencer state encoding and index-slice macro.
`ifndef GC_IT_SLICE
`define GC_IT_SLICE(d) (d)*CNT_WIDTH +: CNT_WIDTH
`endif

package gc_iteration_sequencer_pkg;

    localparam logic [1:0] GC_IT_IDLE = 2'd0;
    localparam logic [1:0] GC_IT_RUN  = 2'd1;
    localparam logic [1:0] GC_IT_DONE = 2'd2;

endpackage

// File: rtl/reduction_and.sv
// Generic reduction AND over a WIDTH-bit vector.
module reduction_and #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_result
);

    assign o_result = &i_data;

endmodule

// File: rtl/gc_iteration_sequencer.sv
// Global Controller iteration-space sequencer: steps a DIMENSION-deep loop nest, innermost first.
// Optional macro GC_ITER_CONTINUOUS_EN: wrap to idx=0 on the final tick and stay in RUN.
module gc_iteration_sequencer
    import gc_iteration_sequencer_pkg::*;
#(
    parameter int DIMENSION = 3,
    parameter int CNT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_load,
    input  logic [DIMENSION*CNT_WIDTH-1:0] cfg_bounds,
    input  logic                           start,
    input  logic                           tick,
    input  logic                           abort,
    output logic                           busy,
    output logic [DIMENSION*CNT_WIDTH-1:0] idx,
    output logic [DIMENSION-1:0]           last,
    output logic                           all_last,
    output logic                           done
);

    logic [1:0]                     r_state;
    logic [1:0]                     w_state_next;
    logic [DIMENSION*CNT_WIDTH-1:0] r_bounds;
    logic [DIMENSION*CNT_WIDTH-1:0] r_idx;
    logic [DIMENSION*CNT_WIDTH-1:0] w_idx_inc;
    logic [DIMENSION-1:0]           w_last;
    logic [DIMENSION-1:0]           w_carry;
    logic                           w_all_last;
`ifdef GC_ITER_CONTINUOUS_EN
    logic                           r_done;
`endif

    // Odometer increment: a dimension wraps only when it is at its bound and receives a carry.
    assign w_carry[0] = 1'b1;
    for (genvar d = 0; d < DIMENSION; d++) begin : g_dim
        assign w_last[d] = (r_idx[`GC_IT_SLICE(d)] == r_bounds[`GC_IT_SLICE(d)]);
        assign w_idx_inc[`GC_IT_SLICE(d)] = !w_carry[d] ? r_idx[`GC_IT_SLICE(d)] :
                                            w_last[d]   ? '0 :
                                            r_idx[`GC_IT_SLICE(d)] + CNT_WIDTH'(1);
        if (d < DIMENSION - 1) begin : g_carry
            assign w_carry[d+1] = w_carry[d] & w_last[d];
        end
    end

    reduction_and #(
        .WIDTH(DIMENSION)
    ) u_reduction_and (
        .i_data  (w_last),
        .o_result(w_all_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= GC_IT_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            GC_IT_IDLE: begin
                if (start) begin
                    w_state_next = GC_IT_RUN;
                end
            end
            GC_IT_RUN: begin
                if (abort) begin
                    w_state_next = GC_IT_IDLE;
                end
`ifndef GC_ITER_CONTINUOUS_EN
                else if (tick && w_all_last) begin
                    w_state_next = GC_IT_DONE;
                end
`endif
            end
            GC_IT_DONE: w_state_next = GC_IT_IDLE;
            default:    w_state_next = GC_IT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bounds <= '0;
            r_idx    <= '0;
        end else begin
            if (r_state == GC_IT_IDLE && cfg_load) begin
                r_bounds <= cfg_bounds;
            end
            if (r_state == GC_IT_RUN) begin
                if (abort) begin
                    r_idx <= '0;
                end else if (tick) begin
                    if (!w_all_last) begin
                        r_idx <= w_idx_inc;
                    end
`ifdef GC_ITER_CONTINUOUS_EN
                    else begin
                        r_idx <= '0;
                    end
`endif
                end
            end else begin
                // DONE always exits to IDLE, so clearing here gives idx=0 on IDLE entry.
                r_idx <= '0;
            end
        end
    end

`ifdef GC_ITER_CONTINUOUS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == GC_IT_RUN) && !abort && tick && w_all_last;
        end
    end
`endif

    always_comb begin
        busy = (r_state == GC_IT_RUN);
`ifdef GC_ITER_CONTINUOUS_EN
        done = r_done;
`else
        done = (r_state == GC_IT_DONE);
`endif
    end

    assign idx      = r_idx;
    assign last     = w_last;
    assign all_last = w_all_last;

endmodule
